// File: rtl/raw_bin2x2_gray.sv
// 2x2 Bayer-quad averaging binner: 8-bit RAW in, half-width/half-height 8-bit grey out.
// Even rows store per-pair sums in a line buffer; odd rows add their pair sums and emit the quad mean.
module raw_bin2x2_gray #(
    parameter int unsigned IMG_HDISP = 640,
    parameter int unsigned ADDR_W    = 9
) (
    input  logic       cmos_pclk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_raw,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_gray,
    output logic       line_ovf
);

    localparam int unsigned COL_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [COL_W-1:0] HDISP_C = COL_W'(IMG_HDISP);
    localparam logic [COL_W-1:0] COL_MAX = '1;

    logic             vsync_q, vsync_d;
    logic             href_q, href_d;
    logic             post_href_q, post_href_d;
    logic             clken_q, clken_d;
    logic [7:0]       gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             row_odd_q, row_odd_d;
    logic [7:0]       pair_q, pair_d;

    logic [8:0]        ram [DEPTH];
    logic [8:0]        rd_q;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] idx;
    logic [8:0]        pair_sum;
    logic [COL_W-1:0]  col_cur;
    logic              row_cur;
    logic              vsync_rise, href_rise, href_fall, accept;

    // Next-state: edge detection, column/row tracking, pair sums and quad output
    always_comb begin
        vsync_d     = per_frame_vsync;
        href_d      = per_frame_href;
        post_href_d = 1'b0;
        clken_d     = 1'b0;
        gray_d      = gray_q;
        ovf_d       = ovf_q;
        col_d       = col_q;
        row_odd_d   = row_odd_q;
        pair_d      = pair_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;

        vsync_rise = per_frame_vsync & ~vsync_q;
        href_rise  = per_frame_href & ~href_q;
        href_fall  = ~per_frame_href & href_q;
        accept     = per_frame_href & per_frame_clken;

        // A pixel on the first href cycle already belongs to column 0 of a fresh frame/line
        col_cur  = href_rise ? '0 : col_q;
        row_cur  = vsync_rise ? 1'b0 : row_odd_q;
        idx      = col_cur[COL_W-1:1];
        pair_sum = 9'(pair_q) + 9'(per_img_raw);

        post_href_d = per_frame_href & row_cur;
        col_d       = col_cur;

        if (accept) begin
            if (col_cur != COL_MAX) begin
                col_d = col_cur + COL_W'(1);
            end
            if (col_cur >= HDISP_C) begin
                ovf_d = 1'b1;
            end else if (!col_cur[0]) begin
                pair_d = per_img_raw;
                ram_re = row_cur;
            end else if (!row_cur) begin
                ram_we = 1'b1;
            end else begin
                clken_d = 1'b1;
                gray_d  = 8'((10'(rd_q) + 10'(pair_sum)) >> 2);
            end
        end

        if (vsync_rise) begin
            row_odd_d = 1'b0;
        end else if (href_fall) begin
            row_odd_d = ~row_odd_q;
        end

        if (href_fall && col_q[0]) begin
            ovf_d = 1'b1;
        end
        if (vsync_rise) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            post_href_q <= 1'b0;
            clken_q     <= 1'b0;
            gray_q      <= '0;
            ovf_q       <= 1'b0;
            col_q       <= '0;
            row_odd_q   <= 1'b0;
            pair_q      <= '0;
        end else begin
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            post_href_q <= post_href_d;
            clken_q     <= clken_d;
            gray_q      <= gray_d;
            ovf_q       <= ovf_d;
            col_q       <= col_d;
            row_odd_q   <= row_odd_d;
            pair_q      <= pair_d;
        end
    end

    // Line buffer; read data only updates on a read, so it holds across clken gaps
    always_ff @(posedge cmos_pclk) begin
        if (ram_we) begin
            ram[idx] <= pair_sum;
        end
        if (ram_re) begin
            rd_q <= ram[idx];
        end
    end

    assign post_frame_vsync = vsync_q;
    assign post_frame_href  = post_href_q;
    assign post_frame_clken = clken_q;
    assign post_img_gray    = gray_q;
    assign line_ovf         = ovf_q;

endmodule

// File: tb/tb_raw_bin2x2_gray.sv
// Randomised bench for raw_bin2x2_gray: frames are stored as pixel arrays and every
// output cycle is compared against quad averages computed directly from those arrays.
module tb_raw_bin2x2_gray;

    localparam int HDISP = 640;

    logic       cmos_pclk = 1'b0;
    logic       rst_n;
    logic       per_frame_vsync, per_frame_href, per_frame_clken;
    logic [7:0] per_img_raw;
    logic       post_frame_vsync, post_frame_href, post_frame_clken;
    logic [7:0] post_img_gray;
    logic       line_ovf;

    raw_bin2x2_gray #(.IMG_HDISP(640), .ADDR_W(9)) dut (
        .cmos_pclk        (cmos_pclk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_raw      (per_img_raw),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_gray    (post_img_gray),
        .line_ovf         (line_ovf)
    );

    always #5 cmos_pclk = ~cmos_pclk;

    int n_cmp = 0;
    int n_err = 0;
    int obs_strobes = 0;
    int exp_strobes = 0;

    logic [7:0] f [8][648];
    int         len [8];

    logic       exp_vs, exp_hr, exp_ce, exp_ovf;
    logic [7:0] exp_gray;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs produced by the previous inputs, then apply new inputs.
    // ovf_ev: 0 none, 1 fault expected to set line_ovf, 2 frame start clears it.
    task automatic tick(input logic vs, input logic hr, input logic ce, input logic [7:0] px,
                        input logic row_odd, input logic nce, input logic [7:0] ngray,
                        input int ovf_ev);
        @(negedge cmos_pclk);
        check_eq("post_vsync", post_frame_vsync, exp_vs);
        check_eq("post_href", post_frame_href, exp_hr);
        check_eq("post_clken", post_frame_clken, exp_ce);
        if (exp_ce) check_eq("post_gray", post_img_gray, exp_gray);
        check_eq("line_ovf", line_ovf, exp_ovf);
        if (post_frame_clken === 1'b1) obs_strobes++;
        per_frame_vsync = vs;
        per_frame_href  = hr;
        per_frame_clken = ce;
        per_img_raw     = px;
        exp_vs = vs;
        exp_hr = hr & row_odd;
        exp_ce = nce;
        if (nce) begin
            exp_gray = ngray;
            exp_strobes++;
        end
        if (ovf_ev == 1) exp_ovf = 1'b1;
        else if (ovf_ev == 2) exp_ovf = 1'b0;
    endtask

    task automatic mid_reset();
        @(posedge cmos_pclk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_vsync", post_frame_vsync, 0);
        check_eq("rst_href", post_frame_href, 0);
        check_eq("rst_clken", post_frame_clken, 0);
        check_eq("rst_gray", post_img_gray, 0);
        check_eq("rst_ovf", line_ovf, 0);
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_raw     = '0;
        if (exp_ce) exp_strobes--;
        repeat (3) @(negedge cmos_pclk);
        rst_n = 1'b1;
        exp_vs = 1'b0; exp_hr = 1'b0; exp_ce = 1'b0; exp_ovf = 1'b0;
    endtask

    // gap: 0 = random 0..2 idle cycles per pixel, otherwise gap-1 idle cycles per pixel
    task automatic run_frame(input int nrows, input int gap, input int abort_row, input int abort_col);
        tick(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 2);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 0);
        for (int r = 0; r < nrows; r++) begin
            logic odd;
            odd = (r % 2) == 1;
            for (int j = 0; j < len[r]; j++) begin
                int idle;
                logic nce;
                logic [7:0] ng;
                int sum;
                if (r == abort_row && j == abort_col) begin
                    mid_reset();
                    return;
                end
                idle = (gap == 0) ? int'($urandom_range(0, 2)) : gap - 1;
                repeat (idle) tick(1'b1, 1'b1, 1'b0, 8'($urandom), odd, 1'b0, 8'd0, 0);
                nce = odd && (j % 2 == 1) && (j < HDISP);
                sum = 0;
                if (nce) sum = f[r-1][j-1] + f[r-1][j] + f[r][j-1] + f[r][j];
                ng = 8'(sum / 4);
                tick(1'b1, 1'b1, 1'b1, f[r][j], odd, nce, ng, (j >= HDISP) ? 1 : 0);
            end
            tick(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, (len[r] % 2 == 1) ? 1 : 0);
            repeat (2) tick(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 0);
        end
        repeat (3) tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 0);
        check_eq("strobe_count", obs_strobes, exp_strobes);
    endtask

    task automatic fill_random(input int nrows, input int width);
        for (int r = 0; r < nrows; r++) begin
            len[r] = width;
            for (int j = 0; j < width; j++) f[r][j] = 8'($urandom);
        end
    endtask

    task automatic fill_directed();
        logic [7:0] r0 [4];
        logic [7:0] r1 [4];
        r0 = '{8'd10, 8'd20, 8'd50, 8'd60};
        r1 = '{8'd30, 8'd41, 8'd70, 8'd80};
        len[0] = 4;
        len[1] = 4;
        for (int j = 0; j < 4; j++) begin
            f[0][j] = r0[j];
            f[1][j] = r1[j];
        end
    endtask

    initial begin
        int s0;
        rst_n = 1'b0;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_raw     = '0;
        exp_vs = 1'b0; exp_hr = 1'b0; exp_ce = 1'b0; exp_ovf = 1'b0; exp_gray = '0;
        repeat (3) @(negedge cmos_pclk);
        check_eq("reset_vsync", post_frame_vsync, 0);
        check_eq("reset_href", post_frame_href, 0);
        check_eq("reset_clken", post_frame_clken, 0);
        check_eq("reset_gray", post_img_gray, 0);
        check_eq("reset_ovf", line_ovf, 0);
        rst_n = 1'b1;

        // Directed 4x2 frame, continuous clken: strobes 25 then 65
        fill_directed();
        s0 = obs_strobes;
        run_frame(2, 1, -1, 0);
        check_eq("directed_strobes", obs_strobes - s0, 2);

        // Same frame with clken every third cycle
        s0 = obs_strobes;
        run_frame(2, 3, -1, 0);
        check_eq("gapped_strobes", obs_strobes - s0, 2);

        // Full-width saturated frame
        for (int r = 0; r < 4; r++) begin
            len[r] = HDISP;
            for (int j = 0; j < HDISP; j++) f[r][j] = 8'hFF;
        end
        s0 = obs_strobes;
        run_frame(4, 1, -1, 0);
        check_eq("full_width_strobes", obs_strobes - s0, 640);

        // Over-long line: last two pixels dropped, line_ovf set
        fill_random(2, 642);
        s0 = obs_strobes;
        run_frame(2, 1, -1, 0);
        check_eq("long_line_strobes", obs_strobes - s0, 320);
        check_eq("long_line_ovf", line_ovf, 1);

        // Odd-length lines (next vsync clears line_ovf first)
        fill_random(2, 5);
        s0 = obs_strobes;
        run_frame(2, 0, -1, 0);
        check_eq("odd_line_strobes", obs_strobes - s0, 2);
        check_eq("odd_line_ovf", line_ovf, 1);

        // Three-row frame: only one output row
        fill_random(3, 6);
        s0 = obs_strobes;
        run_frame(3, 0, -1, 0);
        check_eq("three_row_strobes", obs_strobes - s0, 3);

        // Random frames
        for (int k = 0; k < 6; k++) begin
            int w, h;
            w = int'($urandom_range(1, 24));
            h = int'($urandom_range(1, 8));
            fill_random(h, w);
            run_frame(h, 0, -1, 0);
        end

        // Reset in the middle of an odd row, then a clean frame
        fill_random(4, 12);
        run_frame(4, 0, 1, 5);
        fill_random(4, 10);
        s0 = obs_strobes;
        run_frame(4, 0, -1, 0);
        check_eq("post_reset_strobes", obs_strobes - s0, 10);

        tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
